// File: rtl/toplevel_soc_debug_ocimem_arbiter.sv
// Shares the single-port OCI debug RAM between the JTAG monitor path and the CPU's
// Avalon debug-memory slave. Round-robin arbitration, 1-cycle-latency reads.
module toplevel_soc_debug_ocimem_arbiter #(
    parameter int unsigned RAM_AW = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              take_action_ocimem_a_i,
    input  logic              take_action_ocimem_b_i,
    input  logic [37:0]       jdo_i,
    input  logic [RAM_AW-1:0] cpu_address_i,
    input  logic              cpu_read_i,
    input  logic              cpu_write_i,
    input  logic [31:0]       cpu_writedata_i,
    output logic [31:0]       cpu_readdata_o,
    output logic              cpu_waitrequest_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic              ram_wren_o,
    output logic [31:0]       ram_wdata_o,
    input  logic [31:0]       ram_rdata_i,
    output logic [31:0]       MonDReg_o,
    output logic              monitor_ready_o,
    output logic              jtag_overrun_o
);

    typedef enum logic [1:0] {StIdle, StRdJtag, StRdCpu} state_e;

    state_e            state_q, state_d;
    logic              last_cpu_q, last_cpu_d;
    logic [RAM_AW-1:0] jtag_addr_q, jtag_addr_d;
    logic              slot_full_q, slot_full_d;
    logic              slot_wr_q, slot_wr_d;
    logic [31:0]       slot_data_q, slot_data_d;
    logic [31:0]       mon_q, mon_d;
    logic              ready_q, ready_d;
    logic              overrun_q, overrun_d;
    logic [RAM_AW-1:0] ram_addr_q, ram_addr_d;
    logic [31:0]       ram_wdata_q, ram_wdata_d;
    logic [31:0]       cpu_rdata_q, cpu_rdata_d;

    logic cpu_req;
    logic cpu_ack;
    logic grant_cpu;
    logic unused_jdo;

    assign cpu_req           = cpu_read_i | cpu_write_i;
    assign cpu_waitrequest_o = cpu_req & ~cpu_ack;
    assign MonDReg_o         = mon_q;
    assign monitor_ready_o   = ready_q;
    assign jtag_overrun_o    = overrun_q;
    assign unused_jdo        = ^{jdo_i[37:35], jdo_i[17:0]};

    // CPU wins when JTAG is idle, or on a tie when JTAG had the previous grant.
    assign grant_cpu = cpu_req & (~slot_full_q | ~last_cpu_q);

    always_comb begin
        state_d        = state_q;
        last_cpu_d     = last_cpu_q;
        jtag_addr_d    = jtag_addr_q;
        slot_full_d    = slot_full_q;
        slot_wr_d      = slot_wr_q;
        slot_data_d    = slot_data_q;
        mon_d          = mon_q;
        ready_d        = ready_q;
        overrun_d      = overrun_q;
        cpu_ack        = 1'b0;
        ram_wren_o     = 1'b0;
        ram_addr_o     = ram_addr_q;
        ram_wdata_o    = ram_wdata_q;
        cpu_readdata_o = cpu_rdata_q;

        // Reset abandons any in-flight access: no grant and no acknowledge this cycle.
        if (!reset_i) begin
            case (state_q)
                StIdle: begin
                    if (grant_cpu) begin
                        last_cpu_d = 1'b1;
                        ram_addr_o = cpu_address_i;
                        if (cpu_read_i) begin
                            state_d = StRdCpu;
                        end else begin
                            ram_wren_o  = 1'b1;
                            ram_wdata_o = cpu_writedata_i;
                            cpu_ack     = 1'b1;
                        end
                    end else if (slot_full_q) begin
                        last_cpu_d = 1'b0;
                        ram_addr_o = jtag_addr_q;
                        if (slot_wr_q) begin
                            ram_wren_o  = 1'b1;
                            ram_wdata_o = slot_data_q;
                            slot_full_d = 1'b0;
                            ready_d     = 1'b1;
                            jtag_addr_d = jtag_addr_q + RAM_AW'(1);
                        end else begin
                            state_d = StRdJtag;
                        end
                    end
                end
                StRdJtag: begin
                    mon_d       = ram_rdata_i;
                    slot_full_d = 1'b0;
                    ready_d     = 1'b1;
                    jtag_addr_d = jtag_addr_q + RAM_AW'(1);
                    state_d     = StIdle;
                end
                StRdCpu: begin
                    cpu_ack        = 1'b1;
                    cpu_readdata_o = ram_rdata_i;
                    state_d        = StIdle;
                end
                default: state_d = StIdle;
            endcase

            // JTAG completion needs a full slot, and a full slot drops strobes, so the
            // two never update the same register in one cycle.
            if (take_action_ocimem_a_i || take_action_ocimem_b_i) begin
                if (slot_full_q || (take_action_ocimem_a_i && take_action_ocimem_b_i)) begin
                    overrun_d = 1'b1;
                end
                if (!slot_full_q) begin
                    ready_d = 1'b0;
                    if (take_action_ocimem_a_i) begin
                        jtag_addr_d = jdo_i[18 +: RAM_AW];
                        if (jdo_i[34]) begin
                            slot_full_d = 1'b1;
                            slot_wr_d   = 1'b0;
                        end
                    end else begin
                        mon_d       = jdo_i[34:3];
                        slot_full_d = 1'b1;
                        slot_wr_d   = 1'b1;
                        slot_data_d = jdo_i[34:3];
                    end
                end
            end
        end

        ram_addr_d  = ram_addr_o;
        ram_wdata_d = ram_wdata_o;
        cpu_rdata_d = cpu_readdata_o;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            last_cpu_q  <= 1'b1;
            jtag_addr_q <= '0;
            slot_full_q <= 1'b0;
            slot_wr_q   <= 1'b0;
            slot_data_q <= '0;
            mon_q       <= '0;
            ready_q     <= 1'b0;
            overrun_q   <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_cpu_q  <= last_cpu_d;
            jtag_addr_q <= jtag_addr_d;
            slot_full_q <= slot_full_d;
            slot_wr_q   <= slot_wr_d;
            slot_data_q <= slot_data_d;
            mon_q       <= mon_d;
            ready_q     <= ready_d;
            overrun_q   <= overrun_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
        end
    end

endmodule

// File: tb/tb_toplevel_soc_debug_ocimem_arbiter.sv
// Bench for the OCI memory arbiter: directed cycle table, then randomized traffic
// checked against a transaction-level model with its own copy of the RAM.
module tb_toplevel_soc_debug_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset, sa, sb;
    logic [37:0] jdo;
    logic [7:0]  cpu_address;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_writedata, cpu_readdata;
    logic        cpu_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [31:0] ram_wdata, ram_rdata;
    logic [31:0] mon;
    logic        rdy, ovr;

    logic [31:0] ram [256];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    toplevel_soc_debug_ocimem_arbiter #(.RAM_AW(8)) dut (
        .clk_i                  (clk),
        .reset_i                (reset),
        .take_action_ocimem_a_i (sa),
        .take_action_ocimem_b_i (sb),
        .jdo_i                  (jdo),
        .cpu_address_i          (cpu_address),
        .cpu_read_i             (cpu_read),
        .cpu_write_i            (cpu_write),
        .cpu_writedata_i        (cpu_writedata),
        .cpu_readdata_o         (cpu_readdata),
        .cpu_waitrequest_o      (cpu_waitrequest),
        .ram_addr_o             (ram_addr),
        .ram_wren_o             (ram_wren),
        .ram_wdata_o            (ram_wdata),
        .ram_rdata_i            (ram_rdata),
        .MonDReg_o              (mon),
        .monitor_ready_o        (rdy),
        .jtag_overrun_o         (ovr)
    );

    // Single-port RAM, registered read data.
    always @(posedge clk) begin
        if (ram_wren) ram[ram_addr] <= ram_wdata;
        ram_rdata <= ram[ram_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [37:0] ja(input logic [7:0] ad, input logic rd);
        return {3'b000, rd, 8'h00, ad, 18'h0};
    endfunction

    function automatic logic [37:0] jb(input logic [31:0] d);
        return {3'b000, d, 3'b000};
    endfunction

    typedef struct {
        logic        rst, a, b;
        logic [37:0] jdo;
        logic        rd, wr;
        logic [7:0]  addr;
        logic [31:0] wd;
        logic        e_wait, e_wren;
        logic [7:0]  e_raddr;
        logic [31:0] e_wdata;
        logic        e_chk_rd;
        logic [31:0] e_rdata;
        logic [31:0] e_mon;
        logic        e_rdy, e_ovr;
    } vec_t;

    function automatic vec_t v(input logic rst, a, b, input logic [37:0] j,
                               input logic rd, wr, input logic [7:0] ad, input logic [31:0] wd,
                               input logic ew, ewr, input logic [7:0] era,
                               input logic [31:0] ewd, input logic ecr,
                               input logic [31:0] erd, input logic [31:0] emon,
                               input logic erdy, eovr);
        vec_t r;
        r.rst = rst; r.a = a; r.b = b; r.jdo = j; r.rd = rd; r.wr = wr; r.addr = ad;
        r.wd = wd; r.e_wait = ew; r.e_wren = ewr; r.e_raddr = era; r.e_wdata = ewd;
        r.e_chk_rd = ecr; r.e_rdata = erd; r.e_mon = emon; r.e_rdy = erdy; r.e_ovr = eovr;
        return r;
    endfunction

    // Reference model state (transaction level).
    logic        m_full, m_is_wr, m_rdy, m_ovr, m_last_cpu;
    logic [31:0] m_data, m_mon;
    logic [7:0]  m_jaddr, m_raddr, m_rd_addr;
    int          m_busy;  // 0 none, 1 JTAG read in flight, 2 CPU read in flight
    logic [31:0] m_mem [256];

    task automatic model_reset();
        m_full = 0; m_is_wr = 0; m_rdy = 0; m_ovr = 0; m_last_cpu = 1;
        m_data = 0; m_mon = 0; m_jaddr = 0; m_raddr = 0; m_rd_addr = 0; m_busy = 0;
    endtask

    task automatic model_step(input int cyc, output logic acked);
        logic creq, e_wait, e_wren, old_full;
        logic [31:0] e_wd;
        logic [7:0] e_addr;
        string tag;
        tag = $sformatf("rnd%0d", cyc);
        chk({tag, " mon"}, mon, m_mon);
        chk({tag, " ready"}, {31'b0, rdy}, {31'b0, m_rdy});
        chk({tag, " overrun"}, {31'b0, ovr}, {31'b0, m_ovr});
        creq = cpu_read | cpu_write;
        e_wait = creq; e_wren = 0; e_addr = m_raddr; e_wd = 0;
        old_full = m_full;
        if (reset) begin
            model_reset();
        end else begin
            if (m_busy == 1) begin
                m_mon = m_mem[m_rd_addr]; m_full = 0; m_rdy = 1; m_jaddr = m_jaddr + 1;
                m_busy = 0;
            end else if (m_busy == 2) begin
                e_wait = 0;
                chk({tag, " readdata"}, cpu_readdata, m_mem[m_rd_addr]);
                m_busy = 0;
            end else if (creq && (!m_full || !m_last_cpu)) begin
                m_last_cpu = 1; e_addr = cpu_address; m_raddr = cpu_address;
                if (cpu_read) begin
                    m_busy = 2; m_rd_addr = cpu_address;
                end else begin
                    e_wait = 0; e_wren = 1; e_wd = cpu_writedata;
                    m_mem[cpu_address] = cpu_writedata;
                end
            end else if (m_full) begin
                m_last_cpu = 0; e_addr = m_jaddr; m_raddr = m_jaddr;
                if (m_is_wr) begin
                    e_wren = 1; e_wd = m_data; m_mem[m_jaddr] = m_data;
                    m_full = 0; m_rdy = 1; m_jaddr = m_jaddr + 1;
                end else begin
                    m_busy = 1; m_rd_addr = m_jaddr;
                end
            end
            if (sa || sb) begin
                if (old_full || (sa && sb)) m_ovr = 1;
                if (!old_full) begin
                    m_rdy = 0;
                    if (sa) begin
                        m_jaddr = jdo[25:18];
                        if (jdo[34]) begin m_full = 1; m_is_wr = 0; end
                    end else begin
                        m_mon = jdo[34:3]; m_data = jdo[34:3]; m_full = 1; m_is_wr = 1;
                    end
                end
            end
        end
        chk({tag, " waitrequest"}, {31'b0, cpu_waitrequest}, {31'b0, e_wait});
        chk({tag, " wren"}, {31'b0, ram_wren}, {31'b0, e_wren});
        chk({tag, " ram_addr"}, {24'b0, ram_addr}, {24'b0, e_addr});
        if (e_wren) chk({tag, " wdata"}, ram_wdata, e_wd);
        acked = creq && !e_wait;
    endtask

    vec_t tbl[$];

    initial begin
        logic        acked, c_hold;
        logic [63:0] rnd;
        int          k;
        logic [31:0] D, B1;
        D = 32'hDEADBEEF; B1 = 32'h0BADF00D;

        reset = 1; sa = 0; sb = 0; jdo = 0; cpu_address = 0; cpu_read = 0; cpu_write = 0;
        cpu_writedata = 0;
        repeat (2) @(posedge clk);

        // rst a b jdo rd wr addr wd | wait wren raddr wdata chkrd rdata mon rdy ovr
        tbl.push_back(v(1,0,0,0,0,0,0,0,                     0,0,8'h00,0,0,0,0,0,0));
        tbl.push_back(v(0,1,0,ja(8'h10,0),0,0,0,0,           0,0,8'h00,0,0,0,0,0,0));
        tbl.push_back(v(0,0,1,jb(D),0,0,0,0,                 0,0,8'h00,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,                     0,1,8'h10,D,0,0,D,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,                     0,0,8'h10,0,0,0,D,1,0));
        tbl.push_back(v(0,0,1,jb(B1),0,0,0,0,                0,0,8'h10,0,0,0,D,1,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,                     0,1,8'h11,B1,0,0,B1,0,0));
        tbl.push_back(v(0,1,0,ja(8'h10,1),0,0,0,0,           0,0,8'h11,0,0,0,B1,1,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,                     0,0,8'h10,0,0,0,B1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,                     0,0,8'h10,0,0,0,B1,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,                     0,0,8'h10,0,0,0,D,1,0));
        tbl.push_back(v(0,0,0,0,0,1,8'h20,32'h12345678,      0,1,8'h20,32'h12345678,0,0,D,1,0));
        tbl.push_back(v(0,0,0,0,1,0,8'h20,0,                 1,0,8'h20,0,0,0,D,1,0));
        tbl.push_back(v(0,0,0,0,1,0,8'h20,0,                 0,0,8'h20,0,1,32'h12345678,D,1,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,                     0,0,8'h20,0,0,0,D,1,0));
        tbl.push_back(v(1,0,0,0,0,0,0,0,                     0,0,8'h20,0,0,0,D,1,0));
        tbl.push_back(v(0,1,0,ja(8'h30,0),0,0,0,0,           0,0,8'h00,0,0,0,0,0,0));
        tbl.push_back(v(0,0,1,jb(32'hAAAA5555),0,0,0,0,      0,0,8'h00,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,0,1,8'h05,32'h11112222,
                        1,1,8'h30,32'hAAAA5555,0,0,32'hAAAA5555,0,0));
        tbl.push_back(v(0,0,0,0,0,1,8'h05,32'h11112222,
                        0,1,8'h05,32'h11112222,0,0,32'hAAAA5555,1,0));
        tbl.push_back(v(0,0,1,jb(32'h33334444),0,0,0,0,      0,0,8'h05,0,0,0,32'hAAAA5555,1,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,
                        0,1,8'h31,32'h33334444,0,0,32'h33334444,0,0));
        tbl.push_back(v(0,0,1,jb(32'h55556666),0,0,0,0,      0,0,8'h31,0,0,0,32'h33334444,1,0));
        tbl.push_back(v(0,0,0,0,0,1,8'h06,32'h77778888,
                        0,1,8'h06,32'h77778888,0,0,32'h55556666,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,
                        0,1,8'h32,32'h55556666,0,0,32'h55556666,0,0));
        tbl.push_back(v(0,1,0,ja(8'h10,1),1,0,8'h20,0,       1,0,8'h20,0,0,0,32'h55556666,1,0));
        tbl.push_back(v(0,0,1,jb(32'h99999999),1,0,8'h20,0,
                        0,0,8'h20,0,1,32'h12345678,32'h55556666,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,                     0,0,8'h10,0,0,0,32'h55556666,0,1));
        tbl.push_back(v(0,0,0,0,0,0,0,0,                     0,0,8'h10,0,0,0,32'h55556666,0,1));
        tbl.push_back(v(0,0,0,0,0,0,0,0,                     0,0,8'h10,0,0,0,D,1,1));
        tbl.push_back(v(0,1,0,ja(8'hFF,0),0,0,0,0,           0,0,8'h10,0,0,0,D,1,1));
        tbl.push_back(v(0,0,1,jb(32'hCAFEF00D),0,0,0,0,      0,0,8'h10,0,0,0,D,0,1));
        tbl.push_back(v(0,0,0,0,0,0,0,0,
                        0,1,8'hFF,32'hCAFEF00D,0,0,32'hCAFEF00D,0,1));
        tbl.push_back(v(0,0,1,jb(32'h01020304),0,0,0,0,      0,0,8'hFF,0,0,0,32'hCAFEF00D,1,1));
        tbl.push_back(v(0,0,0,0,0,0,0,0,
                        0,1,8'h00,32'h01020304,0,0,32'h01020304,0,1));
        tbl.push_back(v(0,0,0,0,1,0,8'h05,0,                 1,0,8'h05,0,0,0,32'h01020304,1,1));
        tbl.push_back(v(1,0,0,0,1,0,8'h05,0,                 1,0,8'h05,0,0,0,32'h01020304,1,1));
        tbl.push_back(v(0,0,0,0,1,0,8'h05,0,                 1,0,8'h05,0,0,0,0,0,0));
        tbl.push_back(v(0,0,0,0,1,0,8'h05,0,                 0,0,8'h05,0,1,32'h11112222,0,0,0));
        tbl.push_back(v(0,0,0,0,0,0,0,0,                     0,0,8'h05,0,0,0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge clk);
            #1;
            reset = tbl[i].rst; sa = tbl[i].a; sb = tbl[i].b; jdo = tbl[i].jdo;
            cpu_read = tbl[i].rd; cpu_write = tbl[i].wr; cpu_address = tbl[i].addr;
            cpu_writedata = tbl[i].wd;
            @(negedge clk);
            chk($sformatf("row%0d waitrequest", i), {31'b0, cpu_waitrequest},
                {31'b0, tbl[i].e_wait});
            chk($sformatf("row%0d wren", i), {31'b0, ram_wren}, {31'b0, tbl[i].e_wren});
            chk($sformatf("row%0d ram_addr", i), {24'b0, ram_addr}, {24'b0, tbl[i].e_raddr});
            if (tbl[i].e_wren) chk($sformatf("row%0d wdata", i), ram_wdata, tbl[i].e_wdata);
            if (tbl[i].e_chk_rd)
                chk($sformatf("row%0d readdata", i), cpu_readdata, tbl[i].e_rdata);
            chk($sformatf("row%0d mon", i), mon, tbl[i].e_mon);
            chk($sformatf("row%0d ready", i), {31'b0, rdy}, {31'b0, tbl[i].e_rdy});
            chk($sformatf("row%0d overrun", i), {31'b0, ovr}, {31'b0, tbl[i].e_ovr});
        end

        // Randomized phase: start from a clean reset with the model in step.
        @(posedge clk);
        #1;
        reset = 1; sa = 0; sb = 0; cpu_read = 0; cpu_write = 0;
        @(negedge clk);
        model_reset();
        m_mem = ram;
        c_hold = 0;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            @(posedge clk);
            #1;
            reset = ($urandom_range(0, 199) == 0);
            if (!c_hold) begin
                if ($urandom_range(0, 9) < 4) begin
                    k = $urandom_range(1, 3);
                    cpu_read = (k != 2);
                    cpu_write = (k != 1);
                    cpu_address = 8'($urandom_range(0, 15));
                    cpu_writedata = $urandom;
                    c_hold = 1;
                end else begin
                    cpu_read = 0; cpu_write = 0;
                end
            end
            sa = ($urandom_range(0, 7) == 0);
            sb = ($urandom_range(0, 7) == 0);
            rnd = {$urandom, $urandom};
            jdo = rnd[37:0];
            if (sa) jdo[25:18] = 8'($urandom_range(0, 15));
            @(negedge clk);
            model_step(cyc, acked);
            if (acked) c_hold = 0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
